rr_int_to_pcim_rr: RTL

- Next-generation interrupt-to-PCIM notifier for the FPGA record/replay shell.
- Turns per-channel interrupt pulses into single-beat AXI4 writes into a host-visible notification buffer. Each channel owns one AXI_WIDTH/8-byte slot.
- Over the previous generation it adds: round-robin arbitration, a per-channel payload and sequence number in the written line, acknowledge only on a good B response, error retry, and an arm gate so nothing is written before the buffer base is programmed.

---
 rtl/rr_int_to_pcim_rr.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/rr_int_to_pcim_rr.sv
// rr_int_to_pcim_rr
// Turns per-channel interrupt pulses into single-beat AXI4 writes into a
// host-visible notification buffer. Each channel owns one AXI_WIDTH/8-byte
// slot at base + idx*(AXI_WIDTH/8). A written line carries
// {zeros, payload, seq+1}. The channel is acknowledged only after an OKAY
// B response. A non-OKAY response sets a sticky err and re-queues the channel.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   offset, offset_update  buffer base; the update strobe also arms the block
//   int_req, int_payload   per-channel request pulse and payload (same edge)
//   int_ack                one-cycle acknowledge, at most one bit per cycle
//   err                    sticky error flag for any non-OKAY bresp
//   pcim_aw*/w*/b*         AXI4 write master, single beat, one outstanding
//   dbg_state              current FSM state (IDLE=0, ISSUE=1, WAIT_B=2)
//
// Handshake semantics: a beat transfers on a rising clk edge where valid and
// ready are both high. Once raised, awvalid/wvalid stay high with stable
// awaddr/wdata until their own transfer. The two channels complete
// independently, in either order or on the same edge. bready is tied high.
module rr_int_to_pcim_rr #(
  parameter int          NUM_INT        = 16,
  parameter int          AXI_ADDR_WIDTH = 64,
  parameter int          AXI_WIDTH      = 512,
  parameter int          PAYLOAD_W      = 32,
  parameter logic [15:0] AXI_ID         = 16'h0000
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]     offset,
  input  logic                          offset_update,
  input  logic [NUM_INT-1:0]            int_req,
  input  logic [NUM_INT*PAYLOAD_W-1:0]  int_payload,
  output logic [NUM_INT-1:0]            int_ack,
  output logic                          err,
  output logic                          pcim_awvalid,
  input  logic                          pcim_awready,
  output logic [AXI_ADDR_WIDTH-1:0]     pcim_awaddr,
  output logic [15:0]                   pcim_awid,
  output logic [7:0]                    pcim_awlen,
  output logic [2:0]                    pcim_awsize,
  output logic                          pcim_wvalid,
  input  logic                          pcim_wready,
  output logic [AXI_WIDTH-1:0]          pcim_wdata,
  output logic [AXI_WIDTH/8-1:0]        pcim_wstrb,
  output logic                          pcim_wlast,
  input  logic                          pcim_bvalid,
  input  logic [1:0]                    pcim_bresp,
  output logic                          pcim_bready,
  output logic [1:0]                    dbg_state
);

  localparam int IDX_W  = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
  localparam int STRB_W = AXI_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE = AXI_ADDR_WIDTH'(STRB_W);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT_B = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic                      armed_q, armed_d;
  logic [NUM_INT-1:0]        pending_q, pending_d;
  logic [PAYLOAD_W-1:0]      payload_q [NUM_INT];
  logic [PAYLOAD_W-1:0]      payload_d [NUM_INT];
  logic [31:0]               seq_q [NUM_INT];
  logic [31:0]               seq_d [NUM_INT];
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_WIDTH-1:0]      wdata_q, wdata_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic [NUM_INT-1:0]        ack_q, ack_d;
  logic                      err_q, err_d;

  // First pending channel at or after rr_ptr, wrapping around.
  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  int               cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int j = 0; j < NUM_INT; j++) begin
      cand = int'(rr_ptr_q) + j;
      if (cand >= NUM_INT) cand = cand - NUM_INT;
      if (!gnt_found && pending_q[IDX_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    armed_d   = armed_q;
    pending_d = pending_q;
    payload_d = payload_q;
    seq_d     = seq_q;
    rr_ptr_d  = rr_ptr_q;
    idx_d     = idx_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    ack_d     = '0;
    err_d     = err_q;

    if (offset_update) begin
      base_d  = offset;
      armed_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (armed_q && gnt_found) begin
          pending_d[gnt_idx] = 1'b0;
          rr_ptr_d  = (gnt_idx == IDX_W'(NUM_INT - 1)) ? '0 : gnt_idx + 1'b1;
          idx_d     = gnt_idx;
          awaddr_d  = base_q + (AXI_ADDR_WIDTH'(gnt_idx) * STRIDE);
          wdata_d   = '0;
          wdata_d[31:0]            = seq_q[gnt_idx] + 32'd1;
          wdata_d[32 +: PAYLOAD_W] = payload_q[gnt_idx];
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pcim_awready) awvalid_d = 1'b0;
        if (pcim_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || pcim_awready) && (!wvalid_q || pcim_wready))
          state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (pcim_bvalid) begin
          if (pcim_bresp == 2'b00) begin
            seq_d[idx_q] = seq_q[idx_q] + 32'd1;
            ack_d[idx_q] = 1'b1;
          end else begin
            // Retry through normal arbitration; sequence number is not consumed.
            err_d            = 1'b1;
            pending_d[idx_q] = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Captured last so a request landing on its own grant cycle stays pending.
    for (int i = 0; i < NUM_INT; i++) begin
      if (int_req[i]) begin
        pending_d[i] = 1'b1;
        payload_d[i] = int_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      armed_q   <= 1'b0;
      pending_q <= '0;
      for (int i = 0; i < NUM_INT; i++) begin
        payload_q[i] <= '0;
        seq_q[i]     <= '0;
      end
      rr_ptr_q  <= '0;
      idx_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      ack_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      armed_q   <= armed_d;
      pending_q <= pending_d;
      payload_q <= payload_d;
      seq_q     <= seq_d;
      rr_ptr_q  <= rr_ptr_d;
      idx_q     <= idx_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign int_ack      = ack_q;
  assign err          = err_q;
  assign pcim_awvalid = awvalid_q;
  assign pcim_awaddr  = awaddr_q;
  assign pcim_awid    = AXI_ID;
  assign pcim_awlen   = 8'd0;
  assign pcim_awsize  = 3'($clog2(STRB_W));
  assign pcim_wvalid  = wvalid_q;
  assign pcim_wdata   = wdata_q;
  assign pcim_wstrb   = '1;
  assign pcim_wlast   = 1'b1;
  assign pcim_bready  = 1'b1;
  assign dbg_state    = state_q;

endmodule
